// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch over req/ack, decode, then drive
// ALU / register-file controls one phase at a time. Owns the PC.
module instr_seq_ctrl #(
   parameter int ADDR_W        = 8,
   parameter int PC_RESET      = 0,
   parameter int FETCH_TIMEOUT = 15,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       ir,
   output logic              alusrc,
   output logic [1:0]        alu_op,
   output logic              alu_en,
   output logic              regwrite_data,
   output logic              reg_write,
   output logic              busy,
   output logic              halted,
   output logic              illegal,
   output logic              err,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int TW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
   localparam logic [TW-1:0] WAIT_LAST = TW'(FETCH_TIMEOUT - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b111111;
   localparam logic [5:0] OP_HALT  = 6'b111110;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
   } state_t;

   state_t            state;
   logic [TW-1:0]     wait_cnt;
   logic [5:0]        opcode, funct;
   logic              is_rtype, is_addi, is_halt;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] pc_inc;

   assign opcode    = ir[31:26];
   assign funct     = ir[5:0];
   assign is_addi   = (opcode == OP_ADDI);
   assign is_halt   = (opcode == OP_HALT);
   assign pc_inc    = pc + ADDR_W'(1);
   assign imem_addr = pc;

   always_comb begin
      is_rtype = 1'b0;
      r_op     = 2'b00;
      if (opcode == OP_RTYPE) begin
         case (funct)
            6'b100000: begin is_rtype = 1'b1; r_op = 2'b00; end
            6'b100010: begin is_rtype = 1'b1; r_op = 2'b01; end
            6'b100100: begin is_rtype = 1'b1; r_op = 2'b10; end
            6'b100101: begin is_rtype = 1'b1; r_op = 2'b11; end
            default:   begin is_rtype = 1'b0; r_op = 2'b00; end
         endcase
      end
   end

   // Status outputs are written on each transition so they track the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         pc            <= ADDR_W'(PC_RESET);
         ir            <= '0;
         instr_count   <= '0;
         imem_req      <= 1'b0;
         alusrc        <= 1'b1;
         alu_op        <= 2'b00;
         regwrite_data <= 1'b1;
         alu_en        <= 1'b0;
         reg_write     <= 1'b0;
         busy          <= 1'b0;
         halted        <= 1'b0;
         illegal       <= 1'b0;
         err           <= 1'b0;
      end else begin
         alu_en    <= 1'b0;
         reg_write <= 1'b0;
         illegal   <= 1'b0;
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state    <= S_FETCH;
                  wait_cnt <= '0;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
                  halted   <= 1'b0;
               end
            end
            S_FETCH: begin
               // An ack in the expiry cycle still completes the fetch.
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  state    <= S_DECODE;
                  imem_req <= 1'b0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state    <= S_ERR;
                  imem_req <= 1'b0;
                  busy     <= 1'b0;
                  err      <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            S_DECODE: begin
               if (is_rtype) begin
                  alusrc        <= 1'b1;
                  regwrite_data <= 1'b1;
                  alu_op        <= r_op;
                  alu_en        <= 1'b1;
                  state         <= S_EXEC;
               end else if (is_addi) begin
                  alusrc        <= 1'b0;
                  regwrite_data <= 1'b0;
                  alu_op        <= 2'b00;
                  alu_en        <= 1'b1;
                  state         <= S_EXEC;
               end else if (is_halt) begin
                  pc     <= pc_inc;
                  state  <= S_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  illegal <= 1'b1;
                  pc      <= pc_inc;
                  if (stop) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state    <= S_FETCH;
                     wait_cnt <= '0;
                     imem_req <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               reg_write <= 1'b1;
               state     <= S_WB;
            end
            S_WB: begin
               pc <= pc_inc;
               if (instr_count != {CNT_W{1'b1}})
                  instr_count <= instr_count + CNT_W'(1);
               if (stop) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state    <= S_FETCH;
                  wait_cnt <= '0;
                  imem_req <= 1'b1;
               end
            end
            S_ERR: begin
               state <= S_ERR;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Randomized bench for instr_seq_ctrl: an instruction-level model tracks
// pc / count / controls and the expected phase sequence of each instruction.
module tb_instr_seq_ctrl;
   localparam int AW = 8;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst_n, start, stop, imem_ack;
   logic [31:0]   imem_rdata;
   logic          imem_req, alusrc, alu_en, regwrite_data, reg_write;
   logic          busy, halted, illegal, err;
   logic [AW-1:0] imem_addr, pc;
   logic [31:0]   ir;
   logic [1:0]    alu_op;
   logic [CW-1:0] instr_count;

   always #5 clk = ~clk;

   instr_seq_ctrl #(.ADDR_W(AW), .PC_RESET(0), .FETCH_TIMEOUT(15), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .pc(pc), .ir(ir), .alusrc(alusrc),
      .alu_op(alu_op), .alu_en(alu_en), .regwrite_data(regwrite_data),
      .reg_write(reg_write), .busy(busy), .halted(halted), .illegal(illegal),
      .err(err), .instr_count(instr_count)
   );

   int total = 0;
   int bad   = 0;

   localparam int ST_FETCH = 0, ST_IDLE = 1, ST_HALT = 2;
   localparam int K_ALU = 0, K_ADDI = 1, K_HALT = 2, K_ILL = 3;

   logic [5:0]    functs [4] = '{6'h20, 6'h22, 6'h24, 6'h25};
   logic [AW-1:0] m_pc;
   logic [CW-1:0] m_cnt;
   logic [31:0]   m_ir;
   logic          m_alusrc, m_rwd;
   logic [1:0]    m_aluop;
   int            status;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_pc = '0; m_cnt = '0; m_ir = '0;
      m_alusrc = 1'b1; m_rwd = 1'b1; m_aluop = 2'b00;
      status = ST_IDLE;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_pc"}, pc, m_pc);
      chk({tag, "_ir"}, ir, m_ir);
      chk({tag, "_cnt"}, instr_count, m_cnt);
      chk({tag, "_alusrc"}, alusrc, 1);
      chk({tag, "_aluop"}, alu_op, 0);
      chk({tag, "_rwd"}, regwrite_data, 1);
      chk({tag, "_flags"}, {imem_req, alu_en, reg_write, busy, halted, illegal, err}, 0);
   endtask

   task automatic check_ctrl(input string tag);
      chk({tag, "_alusrc"}, alusrc, m_alusrc);
      chk({tag, "_aluop"}, alu_op, m_aluop);
      chk({tag, "_rwd"}, regwrite_data, m_rwd);
   endtask

   function automatic int classify(input logic [31:0] w, output logic [1:0] op);
      op = 2'b00;
      if (w[31:26] == 6'h3F) return K_ADDI;
      if (w[31:26] == 6'h3E) return K_HALT;
      if (w[31:26] == 6'h00)
         for (int i = 0; i < 4; i++)
            if (w[5:0] == functs[i]) begin
               op = 2'(i);
               return K_ALU;
            end
      return K_ILL;
   endfunction

   function automatic logic [31:0] gen_instr(input int kind);
      logic [31:0] w;
      w = $urandom;
      case (kind)
         K_ALU:  begin w[31:26] = 6'h00; w[5:0] = functs[$urandom_range(0, 3)]; end
         K_ADDI: w[31:26] = 6'h3F;
         K_HALT: w[31:26] = 6'h3E;
         default: begin
            if ($urandom_range(0, 1) == 1) w[31:26] = 6'($urandom_range(1, 61));
            else begin
               w[31:26] = 6'h00;
               if (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25}) w[5:0] = 6'h21;
            end
         end
      endcase
      return w;
   endfunction

   task automatic resume();
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         chk("wait_busy", busy, 0);
         chk("wait_halted", halted, (status == ST_HALT));
         chk("wait_req", imem_req, 0);
         chk("wait_pc", pc, m_pc);
         tick();
      end
      start = 1'b1; tick(); start = 1'b0;
      chk("start_req", imem_req, 1);
      chk("start_busy", busy, 1);
      chk("start_halted", halted, 0);
      chk("start_ill", illegal, 0);
      status = ST_FETCH;
   endtask

   // Expects the DUT in its first FETCH cycle.
   task automatic run_instr(input logic [31:0] w, input int delay, input bit s);
      int k;
      logic [1:0] op;
      if (status != ST_FETCH) resume();
      k = classify(w, op);
      stop = s;
      for (int i = 0; i < delay; i++) begin
         chk("fetch_req", imem_req, 1);
         chk("fetch_addr", imem_addr, m_pc);
         chk("fetch_err", err, 0);
         tick();
      end
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      imem_ack = 1'b1; imem_rdata = w; tick();
      m_ir = w;
      chk("dec_ir", ir, m_ir);
      chk("dec_req", imem_req, 0);
      chk("dec_busy", busy, 1);
      chk("dec_ill", illegal, 0);
      // start and imem_ack during DECODE must both be ignored
      start = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      tick();
      start = 1'b0; imem_ack = 1'b0;
      chk("post_dec_ir", ir, m_ir);
      if (k == K_ALU || k == K_ADDI) begin
         m_alusrc = (k == K_ALU); m_rwd = (k == K_ALU); m_aluop = op;
         chk("exec_en", alu_en, 1);
         chk("exec_wr", reg_write, 0);
         check_ctrl("exec");
         tick();
         chk("wb_wr", reg_write, 1);
         chk("wb_en", alu_en, 0);
         chk("wb_pc", pc, m_pc);
         tick();
         m_pc = m_pc + 1'b1;
         if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
         chk("ret_pc", pc, m_pc);
         chk("ret_cnt", instr_count, m_cnt);
         chk("ret_wr", reg_write, 0);
         chk("ret_busy", busy, !s);
         chk("ret_req", imem_req, !s);
         status = s ? ST_IDLE : ST_FETCH;
      end else if (k == K_HALT) begin
         m_pc = m_pc + 1'b1;
         chk("halt_flag", halted, 1);
         chk("halt_busy", busy, 0);
         chk("halt_pc", pc, m_pc);
         chk("halt_wr", {reg_write, alu_en, imem_req}, 0);
         chk("halt_cnt", instr_count, m_cnt);
         check_ctrl("halt");
         status = ST_HALT;
      end else begin
         m_pc = m_pc + 1'b1;
         chk("ill_pulse", illegal, 1);
         chk("ill_pc", pc, m_pc);
         chk("ill_cnt", instr_count, m_cnt);
         chk("ill_wr", {reg_write, alu_en}, 0);
         chk("ill_busy", busy, !s);
         chk("ill_req", imem_req, !s);
         check_ctrl("ill");
         status = s ? ST_IDLE : ST_FETCH;
      end
      stop = 1'b0;
   endtask

   task automatic timeout_test();
      if (status != ST_FETCH) resume();
      for (int i = 0; i < 15; i++) begin
         chk("to_req", imem_req, 1);
         chk("to_err", err, 0);
         tick();
      end
      chk("to_err_set", err, 1);
      chk("to_busy", busy, 0);
      chk("to_req_off", imem_req, 0);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0020; start = 1'b1;
      tick();
      imem_ack = 1'b0; start = 1'b0;
      tick();
      chk("to_err_sticky", err, 1);
      chk("to_ir_hold", ir, m_ir);
      chk("to_strobes", {reg_write, alu_en, imem_req, busy}, 0);
      rst_n = 1'b0; #1;
      model_reset();
      check_reset("to_rst");
      tick();
      rst_n = 1'b1;
   endtask

   task automatic reset_in_exec();
      if (status != ST_FETCH) resume();
      imem_ack = 1'b1; imem_rdata = gen_instr(K_ALU); tick();
      imem_ack = 1'b0; tick();
      chk("rx_in_exec", alu_en, 1);
      rst_n = 1'b0; #1;
      model_reset();
      check_reset("rx_rst");
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rx_no_write", reg_write, 0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, d;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;

      run_instr(32'h0022_1820, 0, 1'b0);   // ADD, ack same cycle
      run_instr(32'hFC22_0005, 3, 1'b0);   // ADDI, 3-cycle ack delay
      run_instr(32'h0022_1822, 0, 1'b0);   // SUB
      run_instr(32'h0022_1824, 1, 1'b0);   // AND
      run_instr(32'h0022_1825, 0, 1'b1);   // OR, then stop
      run_instr(32'hF800_0000, 0, 1'b0);   // halt
      run_instr(32'h0400_0000, 0, 1'b0);   // illegal opcode 000001
      run_instr(32'h0022_1820, 14, 1'b0);  // ack on the last allowed cycle
      timeout_test();
      reset_in_exec();

      // long random run: wraps the PC and saturates the counter
      for (int n = 0; n < 320; n++) begin
         r = $urandom_range(0, 9);
         d = ($urandom_range(0, 19) == 0) ? 14 : $urandom_range(0, 3);
         run_instr(gen_instr(r < 5 ? K_ALU : r < 7 ? K_ADDI : r == 7 ? K_HALT : K_ILL),
                   d, ($urandom_range(0, 4) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
